// File: rtl/launchpad_song_select_pkg.sv
// Shared constants and FSM encoding for the launchpad song-select front end.
// NUM_KEYS/SONG_W are shared with the downstream MCU.
package launchpad_song_select_pkg;

    localparam int NUM_KEYS            = 16;
    localparam int SONG_W              = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 100000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PENDING  = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

endpackage

// File: rtl/launchpad_song_select_if.sv
// Key/hold inputs and song outputs between the launchpad front end and its user.
interface launchpad_song_select_if;
    import launchpad_song_select_pkg::*;

    logic [NUM_KEYS-1:0] keys;
    logic                hold;
    logic [SONG_W-1:0]   song_input;
    logic                song_valid;
    logic                new_song;
    logic                busy;

    modport master (
        output keys, hold,
        input  song_input, song_valid, new_song, busy
    );

    modport slave (
        input  keys, hold,
        output song_input, song_valid, new_song, busy
    );

endinterface

// File: rtl/launchpad_song_select_key_sync.sv
// Two-flop synchroniser for the raw, asynchronous launchpad key lines.
module key_sync #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_keys,
    output logic [W-1:0] o_ks
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_ks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_ks   <= '0;
        end else begin
            r_meta <= i_keys;
            r_ks   <= r_meta;
        end
    end

    assign o_ks = r_ks;

endmodule

// File: rtl/launchpad_song_select.sv
// Debounces the synchronised launchpad keys and commits a single pressed key
// as the song number for the MCU, with commit pulse, valid flag and busy.
module launchpad_song_select
    import launchpad_song_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    launchpad_song_select_if.slave bus
);

    generate
        if (DEBOUNCE_CYCLES < 2 || ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_param_err
            $error("launchpad_song_select: DEBOUNCE_CYCLES must be >= 2 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (|v) && ((v & (v - 1'b1)) == '0);
    endfunction

    // OR-reduce the indices of set bits; exact only for one-hot input.
    function automatic logic [SONG_W-1:0] encode(input logic [NUM_KEYS-1:0] oh);
        logic [SONG_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (oh[i]) idx = idx | SONG_W'(i);
        end
        return idx;
    endfunction

    logic [NUM_KEYS-1:0] w_ks;
    logic                w_ks_onehot;
    logic                w_cnt_done;
    state_t              r_state;
    state_t              w_next;
    logic [NUM_KEYS-1:0] r_cand;
    logic [CNT_W-1:0]    r_cnt;
    logic [SONG_W-1:0]   r_song;
    logic                r_valid;
    logic                r_new;

    key_sync #(.W(NUM_KEYS)) u_key_sync (
        .clk    (clk),
        .rst_n  (reset),
        .i_keys (bus.keys),
        .o_ks   (w_ks)
    );

    assign w_ks_onehot = is_onehot(w_ks);
    assign w_cnt_done  = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_song  <= '0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_new   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ks_onehot) begin
                        r_cand <= w_ks;
                        r_cnt  <= '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_ks != r_cand)   r_cnt <= '0;
                    else if (!w_cnt_done) r_cnt <= r_cnt + 1'b1;
                end
                ST_COMMIT: begin
                    r_song  <= encode(r_cand);
                    r_valid <= 1'b1;
                    r_new   <= 1'b1;
                    r_cnt   <= '0;
                end
                // Any activity on the keys restarts the release window.
                ST_RELEASE: begin
                    if (w_ks != '0)       r_cnt <= '0;
                    else if (!w_cnt_done) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_ks_onehot) w_next = ST_DEBOUNCE;
            ST_DEBOUNCE: begin
                if (w_ks != r_cand)  w_next = ST_IDLE;
                else if (w_cnt_done) w_next = bus.hold ? ST_PENDING : ST_COMMIT;
            end
            ST_PENDING:  if (!bus.hold) w_next = ST_COMMIT;
            ST_COMMIT:   w_next = ST_RELEASE;
            ST_RELEASE:  if (w_ks == '0 && w_cnt_done) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.song_input = r_song;
        bus.song_valid = r_valid;
        bus.new_song   = r_new;
        bus.busy       = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_launchpad_song_select.sv
// Scoreboard bench for launchpad_song_select with DEBOUNCE_CYCLES=4: directed scenarios then randomized presses.
module tb_launchpad_song_select;
    import launchpad_song_select_pkg::*;

    localparam int DB      = 4;
    localparam int LATENCY = DB + 4;   // drive at negedge -> new_song seen at negedge this many cycles later

    typedef struct {
        int song;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    launchpad_song_select_if bus();

    launchpad_song_select #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A clean single press just driven: the commit is due LATENCY cycles from now.
    task automatic expect_commit(input int song, input int delay);
        exp_t e;
        e.song = song;
        e.cyc  = cyc + delay;
        q.push_back(e);
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.new_song === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: song %0d at cycle %0d, no commit expected", bus.song_input, cyc);
            end else begin
                e = q.pop_front();
                chk("commit_song", int'(bus.song_input), e.song);
                chk("commit_cycle", cyc, e.cyc);
                chk("commit_valid", int'(bus.song_valid), 1);
            end
        end
    end

    initial begin
        int k, a, b, sel;
        reset     = 1'b0;
        bus.keys  = '0;
        bus.hold  = 1'b0;

        // 1: reset
        idle(3);
        chk("rst_song", int'(bus.song_input), 0);
        chk("rst_valid", int'(bus.song_valid), 0);
        chk("rst_new", int'(bus.new_song), 0);
        chk("rst_busy", int'(bus.busy), 0);
        reset = 1'b1;
        idle(1);
        chk("post_rst_busy", int'(bus.busy), 0);

        // 2: clean press of key 5, then release
        bus.keys = 16'h0020;
        expect_commit(5, LATENCY);
        idle(20);
        chk("t2_song", int'(bus.song_input), 5);
        chk("t2_valid", int'(bus.song_valid), 1);
        bus.keys = '0;
        idle(5);
        chk("t2_release_busy", int'(bus.busy), 1);
        idle(2);
        chk("t2_idle_busy", int'(bus.busy), 0);
        idle(3);

        // 3: bouncing key 8, then held
        for (int i = 0; i < 2; i++) begin
            bus.keys = 16'h0100;
            idle(2);
            bus.keys = '0;
            idle(2);
        end
        bus.keys = 16'h0100;
        expect_commit(8, LATENCY);
        idle(15);
        chk("t3_song", int'(bus.song_input), 8);
        bus.keys = '0;
        idle(10);

        // 4: press of key 2 deferred by hold
        bus.hold = 1'b1;
        bus.keys = 16'h0004;
        idle(10);
        bus.keys = '0;
        idle(20);
        chk("t4_busy_pending", int'(bus.busy), 1);
        chk("t4_song_held", int'(bus.song_input), 8);
        bus.hold = 1'b0;
        expect_commit(2, 2);
        idle(12);
        chk("t4_song", int'(bus.song_input), 2);

        // 5: two keys never commit; then key 0
        bus.keys = 16'h0011;
        idle(20);
        chk("t5_multi_song", int'(bus.song_input), 2);
        chk("t5_multi_busy", int'(bus.busy), 0);
        bus.keys = '0;
        idle(10);
        bus.keys = 16'h0001;
        expect_commit(0, LATENCY);
        idle(12);
        chk("t5_song", int'(bus.song_input), 0);
        bus.keys = '0;
        idle(10);

        // 6: commit key 11, then reset in the middle of debouncing key 3
        bus.keys = 16'h0800;
        expect_commit(11, LATENCY);
        idle(12);
        bus.keys = '0;
        idle(10);
        bus.keys = 16'h0008;
        idle(4);
        chk("t6_busy_before", int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_song", int'(bus.song_input), 0);
        chk("t6_rst_valid", int'(bus.song_valid), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_new", int'(bus.new_song), 0);
        idle(3);
        reset = 1'b1;
        expect_commit(3, LATENCY);
        idle(12);
        chk("t6_song", int'(bus.song_input), 3);
        bus.keys = '0;
        idle(10);

        // Randomized: clean single presses, multi-key presses, bouncing presses
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            k   = $urandom_range(0, NUM_KEYS - 1);
            if (sel == 0) begin
                bus.keys = 16'(1) << k;
                expect_commit(k, LATENCY);
                idle($urandom_range(8, 14));
            end else if (sel == 1) begin
                a = $urandom_range(0, NUM_KEYS - 1);
                b = (a + $urandom_range(1, NUM_KEYS - 1)) % NUM_KEYS;
                bus.keys = (16'(1) << a) | (16'(1) << b);
                idle($urandom_range(3, 15));
            end else begin
                repeat ($urandom_range(2, 4)) begin
                    bus.keys = 16'(1) << k;
                    idle($urandom_range(1, 3));
                    bus.keys = '0;
                    idle($urandom_range(1, 3));
                end
                bus.keys = 16'(1) << k;
                expect_commit(k, LATENCY);
                idle($urandom_range(8, 14));
            end
            bus.keys = '0;
            idle($urandom_range(8, 12));
        end

        idle(5);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
